store_size_ss: RTL and testbench

STORE_SIZE_SS -- requirements
Module: store_size_ss

---
 rtl/store_size_ss_pkg.sv | 23 ++
 rtl/store_size_ss_merge.sv | 23 ++
 rtl/store_size_ss.sv | 118 +++++++++++
 tb/tb_store_size_ss.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_size_ss_pkg.sv
// Shared definitions for the store-size and load-size units: size-select
// encodings, the store FSM state set and the wait-counter width.
package store_size_ss_pkg;

  typedef enum logic [1:0] {
    SEL_RSV = 2'b00,
    SEL_SW  = 2'b01,
    SEL_SH  = 2'b10,
    SEL_SB  = 2'b11
  } sel_e;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    WRITE,
    DONE
  } state_e;

  // Wide enough for a memory latency of up to 15 cycles.
  localparam int CNT_W = 4;

endpackage

// File: rtl/store_size_ss_merge.sv
// Lane merge for partial stores: the new halfword/byte always replaces the
// low lanes of the word read back from memory, mirroring how the load-size
// unit extracts lh/lb from the low lanes. The address never shifts lanes.
module store_merge
  import store_size_ss_pkg::*;
(
  input  sel_e        sel,
  input  logic [31:0] rt,
  input  logic [31:0] rdata,
  output logic [31:0] merged
);

  // Pick which low lanes of rt overwrite the read-back word.
  always_comb begin
    merged = rt;
    case (sel)
      SEL_SH:  merged = {rdata[31:16], rt[15:0]};
      SEL_SB:  merged = {rdata[31:8], rt[7:0]};
      default: merged = rt;
    endcase
  end

endmodule

// File: rtl/store_size_ss.sv
// Store-size sequencer: a full-word store writes directly, while a halfword
// or byte store first reads the target word, waits out the memory latency,
// merges the new low lanes in and writes the result back.
module store_size_ss
  import store_size_ss_pkg::*;
#(
  parameter int MEM_LAT = 1
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  sel,
  input  logic [31:0] addr,
  input  logic [31:0] rt_data,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr,
  output logic        busy,
  output logic        done,
  output logic        err
);

  // READ loads latency-1 so that WAIT lasts exactly MEM_LAT cycles,
  // leaving WAIT on the cycle the counter reads zero.
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

  state_e             state_q;
  state_e             state_d;
  sel_e               sel_q;
  logic [31:0]        addr_q;
  logic [31:0]        rt_q;
  logic [31:0]        rdata_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        merged;

  store_merge u_merge (
    .sel    (sel_q),
    .rt     (rt_q),
    .rdata  (rdata_q),
    .merged (merged)
  );

  // State register; reset wins over everything, including a pending start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request capture, latency counter and read-data register.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q   <= SEL_RSV;
      addr_q  <= '0;
      rt_q    <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        sel_q  <= sel_e'(sel);
        addr_q <= addr;
        rt_q   <= rt_data;
      end
      if (state_q == READ) begin
        cnt_q <= LAT_LOAD;
      end else if (state_q == WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (state_q == WAIT && cnt_q == '0) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  // Next-state selection and Moore output decode.
  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          case (sel_e'(sel))
            SEL_SW:  state_d = WRITE;
            SEL_RSV: state_d = DONE;
            default: state_d = READ;
          endcase
        end
      end
      READ:    state_d = WAIT;
      WAIT:    if (cnt_q == '0) state_d = WRITE;
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy = (state_q != IDLE);
    done = (state_q == DONE);
    err  = (state_q == DONE) && (sel_q == SEL_RSV);
    if (state_q == READ || state_q == WAIT || state_q == WRITE) begin
      mem_addr = addr_q;
    end
    if (state_q == WRITE) begin
      mem_wr    = 1'b1;
      mem_wdata = merged;
    end
  end

endmodule

// File: tb/tb_store_size_ss.sv
// Bench for store_size_ss: two instances (memory latency 1 and 3) share the
// request inputs and each gets its own memory read data.
module tb_store_size_ss;
  import store_size_ss_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  sel;
  logic [31:0] addr;
  logic [31:0] rt_data;
  logic [31:0] memRdata [2];
  logic [31:0] memAddr [2];
  logic [31:0] memWdata [2];
  logic        memWr [2];
  logic        busy [2];
  logic        done [2];
  logic        err [2];

  int checks = 0;
  int errors = 0;

  int          wrCount [2];
  int          doneCycle [2];
  int          errCount [2];
  int          cycBad [2];
  logic [31:0] wrData [2];
  logic [31:0] wrAddr [2];
  string       firstBad [2];

  store_size_ss #(.MEM_LAT(1)) dut0 (
    .clk(clk), .reset(reset), .start(start), .sel(sel), .addr(addr),
    .rt_data(rt_data), .mem_rdata(memRdata[0]), .mem_addr(memAddr[0]),
    .mem_wdata(memWdata[0]), .mem_wr(memWr[0]), .busy(busy[0]),
    .done(done[0]), .err(err[0])
  );

  store_size_ss #(.MEM_LAT(3)) dut1 (
    .clk(clk), .reset(reset), .start(start), .sel(sel), .addr(addr),
    .rt_data(rt_data), .mem_rdata(memRdata[1]), .mem_addr(memAddr[1]),
    .mem_wdata(memWdata[1]), .mem_wr(memWr[1]), .busy(busy[1]),
    .done(done[1]), .err(err[1])
  );

  always #5 clk = ~clk;

  // Memory latency of each instance.
  function automatic int latOf(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Cycle (counted from the start edge) in which done is expected.
  function automatic int modelDone(input logic [1:0] s, input int lat);
    if (s == SEL_SW) return 2;
    if (s == SEL_RSV) return 1;
    return 3 + lat;
  endfunction

  // Word written back: bytes kept from memory are selected by a mask.
  function automatic logic [31:0] modelWord(input logic [1:0] s, input logic [31:0] r,
                                            input logic [31:0] w);
    logic [31:0] keep;
    if (s == SEL_SW) keep = 32'h0000_0000;
    else if (s == SEL_SH) keep = 32'hFFFF_0000;
    else keep = 32'hFFFF_FF00;
    return (w & keep) | (r & ~keep);
  endfunction

  // Issue one store, present the memory word only during the last wait
  // cycle of each instance, and compare every output cycle by cycle.
  task automatic applyStimulus(input logic [1:0] s, input logic [31:0] a,
                               input logic [31:0] r, input logic [31:0] w,
                               input bit holdStart, input int cycles);
    int dn [2];
    logic expWr, expBusy, expDone, expErr;
    logic [31:0] expAddr, expWdata;
    for (int d = 0; d < 2; d++) begin
      wrCount[d] = 0; doneCycle[d] = -1; errCount[d] = 0; cycBad[d] = 0;
      wrData[d] = '0; wrAddr[d] = '0; firstBad[d] = "";
      dn[d] = modelDone(s, latOf(d));
      memRdata[d] = $urandom;
    end
    start = 1'b1; sel = s; addr = a; rt_data = r;
    for (int k = 1; k <= cycles; k++) begin
      @(posedge clk); #1;
      start = holdStart && (k <= dn[0]);
      sel = 2'($urandom); addr = $urandom; rt_data = $urandom;
      for (int d = 0; d < 2; d++) begin
        memRdata[d] = (k == latOf(d) + 1) ? w : $urandom;
        expBusy  = (k <= dn[d]);
        expDone  = (k == dn[d]);
        expErr   = expDone && (s == SEL_RSV);
        expWr    = (s != SEL_RSV) && (k == dn[d] - 1);
        expAddr  = ((s != SEL_RSV) && (k < dn[d])) ? a : 32'h0;
        expWdata = expWr ? modelWord(s, r, w) : 32'h0;
        if (memWr[d]) begin
          wrCount[d]++; wrData[d] = memWdata[d]; wrAddr[d] = memAddr[d];
        end
        if (done[d] && doneCycle[d] < 0) doneCycle[d] = k;
        if (err[d]) errCount[d]++;
        if ({memWr[d], busy[d], done[d], err[d]} !== {expWr, expBusy, expDone, expErr}
            || memAddr[d] !== expAddr || memWdata[d] !== expWdata) begin
          if (cycBad[d] == 0)
            firstBad[d] = $sformatf("k=%0d wr/busy/done/err=%b%b%b%b addr=%h wdata=%h need %b%b%b%b %h %h",
              k, memWr[d], busy[d], done[d], err[d], memAddr[d], memWdata[d],
              expWr, expBusy, expDone, expErr, expAddr, expWdata);
          cycBad[d]++;
        end
      end
    end
    start = 1'b0;
  endtask

  // Outputs idle under reset, and a start held during reset is dropped.
  task automatic test_reset();
    reset = 1'b1; start = 1'b1; sel = SEL_SW; addr = 32'h44; rt_data = 32'h55;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({memWr[d], busy[d], done[d], err[d]} !== 4'b0 || memAddr[d] !== 32'h0 || memWdata[d] !== 32'h0) begin
        errors++;
        $display("[TB] FAIL reset_outputs dut%0d: got wr/busy/done/err=%b%b%b%b addr=%h wdata=%h, need all zero",
                 d, memWr[d], busy[d], done[d], err[d], memAddr[d], memWdata[d]);
      end
    end
    reset = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (busy[d] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_start_ignored dut%0d: busy=%b need 0", d, busy[d]);
      end
    end
  endtask

  task automatic test_sw();
    applyStimulus(SEL_SW, 32'h40, 32'hDEADBEEF, 32'h0BAD0BAD, 1'b0, 3);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (cycBad[d] !== 0) begin errors++; $display("[TB] FAIL sw_cycle dut%0d: %s", d, firstBad[d]); end
      checks++;
      if (wrData[d] !== 32'hDEADBEEF || wrAddr[d] !== 32'h40) begin
        errors++;
        $display("[TB] FAIL sw_write dut%0d: got %h@%h need DEADBEEF@00000040", d, wrData[d], wrAddr[d]);
      end
      checks++;
      if (doneCycle[d] !== 2) begin errors++; $display("[TB] FAIL sw_done dut%0d: got t+%0d need t+2", d, doneCycle[d]); end
    end
  endtask

  task automatic test_sh();
    applyStimulus(SEL_SH, 32'h80, 32'hAAAABBBB, 32'h11223344, 1'b0, 7);
    checks++;
    if (wrData[0] !== 32'h1122BBBB) begin errors++; $display("[TB] FAIL sh_data dut0: got %h need 1122BBBB", wrData[0]); end
    checks++;
    if (doneCycle[0] !== 4) begin errors++; $display("[TB] FAIL sh_done dut0: got t+%0d need t+4", doneCycle[0]); end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (cycBad[d] !== 0) begin errors++; $display("[TB] FAIL sh_cycle dut%0d: %s", d, firstBad[d]); end
    end
  endtask

  task automatic test_sb();
    applyStimulus(SEL_SB, 32'hC0, 32'h000000CC, 32'h11223344, 1'b0, 7);
    checks++;
    if (wrData[1] !== 32'h112233CC) begin errors++; $display("[TB] FAIL sb_data dut1: got %h need 112233CC", wrData[1]); end
    checks++;
    if (doneCycle[1] !== 6) begin errors++; $display("[TB] FAIL sb_done dut1: got t+%0d need t+6", doneCycle[1]); end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (cycBad[d] !== 0) begin errors++; $display("[TB] FAIL sb_cycle dut%0d: %s", d, firstBad[d]); end
    end
  endtask

  task automatic test_reserved();
    applyStimulus(SEL_RSV, 32'h10, 32'h12345678, 32'h9ABCDEF0, 1'b0, 4);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (cycBad[d] !== 0) begin errors++; $display("[TB] FAIL rsv_cycle dut%0d: %s", d, firstBad[d]); end
      checks++;
      if (doneCycle[d] !== 1 || errCount[d] !== 1 || wrCount[d] !== 0) begin
        errors++;
        $display("[TB] FAIL rsv_result dut%0d: done t+%0d err %0d writes %0d, need t+1 1 0",
                 d, doneCycle[d], errCount[d], wrCount[d]);
      end
    end
  endtask

  // start is held high with random requests while the store is busy.
  task automatic test_start_ignored();
    applyStimulus(SEL_SB, 32'h300, 32'h0000005A, 32'h01020304, 1'b1, 7);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (cycBad[d] !== 0) begin errors++; $display("[TB] FAIL busy_start_cycle dut%0d: %s", d, firstBad[d]); end
      checks++;
      if (wrCount[d] !== 1 || wrData[d] !== 32'h0102035A || wrAddr[d] !== 32'h300) begin
        errors++;
        $display("[TB] FAIL busy_start_write dut%0d: %0d writes %h@%h need 1 0102035A@00000300",
                 d, wrCount[d], wrData[d], wrAddr[d]);
      end
    end
  endtask

  // Reset lands while both instances sit in WAIT of a halfword store.
  task automatic test_reset_wait();
    int writes [2];
    writes[0] = 0; writes[1] = 0;
    start = 1'b1; sel = SEL_SH; addr = 32'h100; rt_data = 32'hAAAABBBB;
    memRdata[0] = 32'h11223344; memRdata[1] = 32'h11223344;
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      for (int d = 0; d < 2; d++) if (memWr[d]) writes[d]++;
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (busy[d] !== 1'b1 || memAddr[d] !== 32'h100) begin
        errors++;
        $display("[TB] FAIL rstwait_pre dut%0d: busy=%b addr=%h need 1 00000100", d, busy[d], memAddr[d]);
      end
    end
    reset = 1'b1; start = 1'b1; sel = SEL_SW;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({memWr[d], busy[d], done[d], err[d]} !== 4'b0 || memAddr[d] !== 32'h0 || memWdata[d] !== 32'h0) begin
        errors++;
        $display("[TB] FAIL rstwait_idle dut%0d: wr/busy/done/err=%b%b%b%b addr=%h wdata=%h need all zero",
                 d, memWr[d], busy[d], done[d], err[d], memAddr[d], memWdata[d]);
      end
    end
    repeat (6) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) if (memWr[d] || busy[d]) writes[d]++;
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (writes[d] !== 0) begin errors++; $display("[TB] FAIL rstwait_nowrite dut%0d: %0d write/busy cycles need 0", d, writes[d]); end
    end
  endtask

  // sw, then sb issued in the cycle right after DONE.
  task automatic test_back_to_back();
    applyStimulus(SEL_SW, 32'h200, 32'h12345678, 32'h0, 1'b0, 3);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (cycBad[d] !== 0 || wrCount[d] !== 1 || wrData[d] !== 32'h12345678) begin
        errors++;
        $display("[TB] FAIL b2b_first dut%0d: %0d writes data %h need 1 12345678 %s", d, wrCount[d], wrData[d], firstBad[d]);
      end
    end
    applyStimulus(SEL_SB, 32'h204, 32'h000000A5, 32'hCAFEF00D, 1'b0, 7);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (cycBad[d] !== 0 || wrCount[d] !== 1 || wrData[d] !== 32'hCAFEF0A5 || doneCycle[d] !== 3 + latOf(d)) begin
        errors++;
        $display("[TB] FAIL b2b_second dut%0d: %0d writes data %h done t+%0d need 1 CAFEF0A5 t+%0d %s",
                 d, wrCount[d], wrData[d], doneCycle[d], 3 + latOf(d), firstBad[d]);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]  s;
    logic [31:0] a, r, w, want;
    bit          hold;
    for (int i = 0; i < 30; i++) begin
      s = 2'($urandom_range(0, 3)); a = $urandom; r = $urandom; w = $urandom;
      hold = 1'($urandom_range(0, 1));
      applyStimulus(s, a, r, w, hold, modelDone(s, 3) + 1);
      want = modelWord(s, r, w);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (cycBad[d] !== 0) begin errors++; $display("[TB] FAIL rand%0d_cycle dut%0d sel=%b: %s", i, d, s, firstBad[d]); end
        checks++;
        if (doneCycle[d] !== modelDone(s, latOf(d))) begin
          errors++;
          $display("[TB] FAIL rand%0d_done dut%0d sel=%b: t+%0d need t+%0d", i, d, s, doneCycle[d], modelDone(s, latOf(d)));
        end
        checks++;
        if (s == SEL_RSV) begin
          if (wrCount[d] !== 0 || errCount[d] !== 1) begin
            errors++;
            $display("[TB] FAIL rand%0d_rsv dut%0d: writes %0d errs %0d need 0 1", i, d, wrCount[d], errCount[d]);
          end
        end else if (wrCount[d] !== 1 || wrData[d] !== want || wrAddr[d] !== a || errCount[d] !== 0) begin
          errors++;
          $display("[TB] FAIL rand%0d_write dut%0d sel=%b: %0d writes %h@%h errs %0d need 1 %h@%h 0",
                   i, d, s, wrCount[d], wrData[d], wrAddr[d], errCount[d], want, a);
        end
      end
    end
  endtask

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence.
  initial begin
    reset = 1'b1; start = 1'b0; sel = 2'b00; addr = '0; rt_data = '0;
    memRdata[0] = '0; memRdata[1] = '0;
    test_reset();
    test_sw();
    test_sh();
    test_sb();
    test_reserved();
    test_start_ignored();
    test_reset_wait();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
